sb_param_ccff: RTL and testbench

- Parametrised successor of the fixed-size corner switch block. It has CHAN_WIDTH tracks on the bottom and left sides and selectable mux size (2 or 4 inputs per track).
- A shadowed configuration chain lets the FPGA fabric keep routing on the last committed configuration while a new bitstream shifts in.
- It adds a bit counter, load-state FSM, commit handshake and error reporting on top of the scan-chain style ccff.
- Sits at the top-right corner tile of the fabric and chains through ccff_head/ccff_tail like the other tiles.

---
 rtl/sb_param_ccff_if.sv | 47 ++++
 rtl/sb_param_ccff.sv | 170 +++++++++++++++++
 tb/tb_sb_param_ccff.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sb_param_ccff_if.sv
// Bus bundle for the sb_param_ccff corner switch block: configuration chain
// signals plus the routing channels and grid pins. Optional member
// cfg_parity exists only when CCFF_PARITY_EN is defined.
interface sb_param_ccff_if #(
  parameter int CHAN_WIDTH = 9
);
  // Configuration chain
  logic                  ccff_head;
  logic                  ccff_en;
  logic                  cfg_commit;
`ifdef CCFF_PARITY_EN
  logic                  cfg_parity;
`endif
  logic                  ccff_tail;
  logic                  cfg_done;
  logic                  cfg_err;

  // Routing
  logic [CHAN_WIDTH-1:0] chany_bottom_in;
  logic [CHAN_WIDTH-1:0] chanx_left_in;
  logic [CHAN_WIDTH-1:0] bottom_grid_pin;
  logic [CHAN_WIDTH-1:0] left_grid_pin;
  logic [CHAN_WIDTH-1:0] chany_bottom_out;
  logic [CHAN_WIDTH-1:0] chanx_left_out;

  // Fabric / bitstream loader side
  modport master (
`ifdef CCFF_PARITY_EN
    output cfg_parity,
`endif
    output ccff_head, ccff_en, cfg_commit,
    output chany_bottom_in, chanx_left_in, bottom_grid_pin, left_grid_pin,
    input  ccff_tail, cfg_done, cfg_err,
    input  chany_bottom_out, chanx_left_out
  );

  // Switch block side
  modport slave (
`ifdef CCFF_PARITY_EN
    input  cfg_parity,
`endif
    input  ccff_head, ccff_en, cfg_commit,
    input  chany_bottom_in, chanx_left_in, bottom_grid_pin, left_grid_pin,
    output ccff_tail, cfg_done, cfg_err,
    output chany_bottom_out, chanx_left_out
  );
endinterface

// File: rtl/sb_param_ccff.sv
// sb_param_ccff: top-right corner switch block with CHAN_WIDTH tracks on the
// bottom and left sides, MUX_SIZE-input routing muxes, and a shadowed
// configuration chain (shift register sr, active register act).
// Routing always follows act; sr only reaches act through an accepted commit.
// Optional build macro: CCFF_PARITY_EN adds a parity check on commit.
//
// Load protocol: ccff_en is a per-cycle qualifier -- every rising prog_clk
// edge with ccff_en=1 shifts exactly one bit from ccff_head. cfg_commit is a
// single-cycle request sampled on the edge; it is accepted only when the
// chain is FULL (and parity matches, when enabled), otherwise it is dropped
// and answered with a one-cycle cfg_err pulse. There is no back-pressure.
module sb_param_ccff #(
  parameter  int CHAN_WIDTH = 9,
  parameter  int MUX_SIZE   = 2,
  localparam int SEL_W      = $clog2(MUX_SIZE),
  localparam int CFG_BITS   = 2 * CHAN_WIDTH * SEL_W,
  localparam int CNT_W      = $clog2(CFG_BITS + 1)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  sb_param_ccff_if.slave   bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  if ((MUX_SIZE != 2) && (MUX_SIZE != 4)) begin : g_bad_mux_size
    $error("sb_param_ccff: MUX_SIZE must be 2 or 4");
  end

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_FULL    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] act_q, act_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;

  logic shift;
  logic parity_ok;
  logic accept;
  logic reject;

  assign shift = bus.ccff_en;

`ifdef CCFF_PARITY_EN
  assign parity_ok = ((^sr_q) == bus.cfg_parity);
`else
  assign parity_ok = 1'b1;
`endif

  assign accept = bus.cfg_commit && (state_q == S_FULL) && parity_ok;
  assign reject = bus.cfg_commit && !accept;

  // Next-state: chain shift, commit into act, bit counter and load FSM
  always_comb begin
    sr_d    = sr_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (shift) begin
      sr_d = {sr_q[CFG_BITS-2:0], bus.ccff_head};
    end

    if (accept) begin
      // act captures the pre-shift chain; a simultaneous shift starts a new load
      act_d = sr_q;
      if (shift) begin
        cnt_d   = CNT_W'(1);
        state_d = S_LOADING;
      end else begin
        cnt_d   = '0;
        state_d = S_EMPTY;
      end
    end else if (shift) begin
      case (state_q)
        S_EMPTY: begin
          cnt_d   = CNT_W'(1);
          state_d = S_LOADING;
        end
        S_LOADING: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          // counter saturates; oldest bits fall out of ccff_tail
          cnt_d = cnt_q;
        end
        default: begin
          cnt_d   = '0;
          state_d = S_EMPTY;
        end
      endcase
    end

    cfg_done_d = (state_d == S_FULL);
    cfg_err_d  = reject;
  end

  // All configuration state, async active-low reset
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sr_q       <= '0;
      act_q      <= '0;
      cnt_q      <= '0;
      state_q    <= S_EMPTY;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      act_q      <= act_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.ccff_tail = sr_q[CFG_BITS-1];
  assign bus.cfg_done  = cfg_done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign dbg_state     = state_q;
  assign dbg_cnt       = cnt_q;

  logic [1:0]            sel_b, sel_l;
  logic [3:0]            in_b, in_l;
  logic [CHAN_WIDTH-1:0] bot_out, left_out;

  // Routing muxes: zero-latency selection driven only by act
  always_comb begin
    sel_b    = '0;
    sel_l    = '0;
    in_b     = '0;
    in_l     = '0;
    bot_out  = '0;
    left_out = '0;
    for (int i = 0; i < CHAN_WIDTH; i++) begin
      // With MUX_SIZE=2 the upper select bit stays 0, so only inputs 0-1 are reachable
      sel_b             = '0;
      sel_b[SEL_W-1:0]  = act_q[i*SEL_W +: SEL_W];
      sel_l             = '0;
      sel_l[SEL_W-1:0]  = act_q[(CHAN_WIDTH+i)*SEL_W +: SEL_W];

      in_b = {bus.chanx_left_in[(i + CHAN_WIDTH - 1) % CHAN_WIDTH],
              bus.chanx_left_in[i],
              bus.chanx_left_in[(i + 1) % CHAN_WIDTH],
              bus.bottom_grid_pin[i]};
      in_l = {bus.chany_bottom_in[(i + 1) % CHAN_WIDTH],
              bus.chany_bottom_in[i],
              bus.chany_bottom_in[(i + CHAN_WIDTH - 1) % CHAN_WIDTH],
              bus.left_grid_pin[i]};

      bot_out[i]  = in_b[sel_b];
      left_out[i] = in_l[sel_l];
    end
  end

  assign bus.chany_bottom_out = bot_out;
  assign bus.chanx_left_out   = left_out;

endmodule

// File: tb/tb_sb_param_ccff.sv
// Directed testbench for sb_param_ccff with CHAN_WIDTH=4, MUX_SIZE=4
// (16-bit configuration chain). Expected values are hand-computed from the
// static channel inputs below.
module tb_sb_param_ccff;

  localparam int W     = 4;
  localparam int MS    = 4;
  localparam int CNT_W = 5;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // clock / reset
  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;
  always #5 prog_clk = ~prog_clk;

  sb_param_ccff_if #(.CHAN_WIDTH(W)) bus ();
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  sb_param_ccff #(.CHAN_WIDTH(W), .MUX_SIZE(MS)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // driver: apply inputs for one clock edge, return at the following negedge
  task automatic step(input logic en, input logic head, input logic commit);
    bus.ccff_en    = en;
    bus.ccff_head  = head;
    bus.cfg_commit = commit;
    @(posedge prog_clk);
    @(negedge prog_clk);
    bus.ccff_en    = 1'b0;
    bus.ccff_head  = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  // shift a full 16-bit word, MSB first, so that sr == v afterwards
  task automatic load_word(input logic [15:0] v);
    for (int k = 15; k >= 0; k--) step(1'b1, v[k], 1'b0);
  endtask

  initial begin
    bus.ccff_en         = 1'b0;
    bus.ccff_head       = 1'b0;
    bus.cfg_commit      = 1'b0;
`ifdef CCFF_PARITY_EN
    bus.cfg_parity      = 1'b0;
`endif
    bus.bottom_grid_pin = 4'b1010;
    bus.left_grid_pin   = 4'b0110;
    bus.chanx_left_in   = 4'b0001;
    bus.chany_bottom_in = 4'b1001;

    // reset then idle
    @(negedge prog_clk);
    @(negedge prog_clk);
    check("rst_bot_out", 32'(bus.chany_bottom_out), 32'h0000000a);
    check("rst_left_out", 32'(bus.chanx_left_out), 32'h00000006);
    check("rst_done", 32'(bus.cfg_done), 32'h0);
    check("rst_tail", 32'(bus.ccff_tail), 32'h0);
    check("rst_err", 32'(bus.cfg_err), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_EMPTY));
    check("rst_cnt", 32'(dbg_cnt), 32'h0);
    pReset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("idle_bot_out", 32'(bus.chany_bottom_out), 32'h0000000a);

    // full load with mux1 sel=2'b10 (act[3]=1), then commit
    load_word(16'h0008);
    check("load_done", 32'(bus.cfg_done), 32'h1);
    check("load_state", 32'(dbg_state), 32'(ST_FULL));
    check("load_cnt", 32'(dbg_cnt), 32'd16);
    check("shadow_bot_out", 32'(bus.chany_bottom_out), 32'h0000000a);
    step(1'b0, 1'b0, 1'b1);
    check("commit_bot_out", 32'(bus.chany_bottom_out), 32'h00000008);
    check("commit_left_out", 32'(bus.chanx_left_out), 32'h00000006);
    check("commit_done", 32'(bus.cfg_done), 32'h0);
    check("commit_state", 32'(dbg_state), 32'(ST_EMPTY));
    check("commit_err", 32'(bus.cfg_err), 32'h0);

    // 15 bits then commit: rejected
    for (int k = 0; k < 15; k++) step(1'b1, 1'b1, 1'b0);
    check("part_done", 32'(bus.cfg_done), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("rej_err", 32'(bus.cfg_err), 32'h1);
    check("rej_state", 32'(dbg_state), 32'(ST_LOADING));
    check("rej_cnt", 32'(dbg_cnt), 32'd15);
    check("rej_bot_out", 32'(bus.chany_bottom_out), 32'h00000008);
    step(1'b0, 1'b0, 1'b0);
    check("rej_err_pulse", 32'(bus.cfg_err), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    check("last_bit_done", 32'(bus.cfg_done), 32'h1);
    check("last_bit_state", 32'(dbg_state), 32'(ST_FULL));

    // commit + shift together in FULL: act = pre-shift 0xffff
    step(1'b1, 1'b0, 1'b1);
    check("cs_done", 32'(bus.cfg_done), 32'h0);
    check("cs_cnt", 32'(dbg_cnt), 32'd1);
    check("cs_state", 32'(dbg_state), 32'(ST_LOADING));
    check("cs_bot_out", 32'(bus.chany_bottom_out), 32'h00000002);
    check("cs_left_out", 32'(bus.chanx_left_out), 32'h0000000c);

    // asynchronous reset mid-load
    #1 pReset = 1'b0;
    #1;
    check("arst_bot_out", 32'(bus.chany_bottom_out), 32'h0000000a);
    check("arst_left_out", 32'(bus.chanx_left_out), 32'h00000006);
    check("arst_state", 32'(dbg_state), 32'(ST_EMPTY));
    check("arst_cnt", 32'(dbg_cnt), 32'h0);
    check("arst_done", 32'(bus.cfg_done), 32'h0);
    @(negedge prog_clk);
    pReset = 1'b1;

    // tail timing: first bit 1 then zeros
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 1'b0);
    check("tail_15", 32'(bus.ccff_tail), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    check("tail_16", 32'(bus.ccff_tail), 32'h1);
    check("tail_16_done", 32'(bus.cfg_done), 32'h1);
    // second word 0x0002 keeps streaming through the chain
    step(1'b1, 1'b0, 1'b0);
    check("tail_17", 32'(bus.ccff_tail), 32'h0);
    check("sat_cnt", 32'(dbg_cnt), 32'd16);
    check("sat_state", 32'(dbg_state), 32'(ST_FULL));
    for (int k = 14; k >= 0; k--) step(1'b1, (k == 1), 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("w2_bot_out", 32'(bus.chany_bottom_out), 32'h0000000b);
    check("w2_left_out", 32'(bus.chanx_left_out), 32'h00000006);

    // select index 1 on bottom track 1 and left track 0
    load_word(16'h0104);
    step(1'b0, 1'b0, 1'b1);
    check("w3_bot_out", 32'(bus.chany_bottom_out), 32'h00000008);
    check("w3_left_out", 32'(bus.chanx_left_out), 32'h00000007);

`ifdef CCFF_PARITY_EN
    // 3 ones -> odd parity; parity 0 is rejected, parity 1 accepted
    load_word(16'h0016);
    bus.cfg_parity = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("par_rej_err", 32'(bus.cfg_err), 32'h1);
    check("par_rej_state", 32'(dbg_state), 32'(ST_FULL));
    check("par_rej_cnt", 32'(dbg_cnt), 32'd16);
    check("par_rej_bot_out", 32'(bus.chany_bottom_out), 32'h00000008);
    bus.cfg_parity = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    check("par_ok_err", 32'(bus.cfg_err), 32'h0);
    check("par_ok_state", 32'(dbg_state), 32'(ST_EMPTY));
    check("par_ok_bot_out", 32'(bus.chany_bottom_out), 32'h00000009);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
